// File: rtl/dvp_tx_pkg.sv
// Shared types and constants for the DVP pattern transmitter.
package dvp_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBACK,
        ST_ACTIVE,
        ST_VFRONT
    } state_e;

    localparam logic [1:0] PAT_BARS    = 2'd0;
    localparam logic [1:0] PAT_GRAD    = 2'd1;
    localparam logic [1:0] PAT_CHECKER = 2'd2;
    localparam logic [1:0] PAT_COUNTER = 2'd3;

    // Index 0 is the leftmost bar.
    localparam logic [7:0][15:0] BAR_COLOURS = {
        16'h0000, 16'h001F, 16'hF800, 16'hF81F,
        16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
    };

endpackage

// File: rtl/dvp_pixel_gen.sv
// Combinational RGB565 test-pattern function of (sel, x, y, pixcnt).
module dvp_pixel_gen
    import dvp_tx_pkg::*;
#(
    parameter int H_ACTIVE = 640
) (
    input  logic [1:0]  sel,
    input  logic [15:0] x,
    input  logic [3:0]  row,
    input  logic [15:0] pixcnt,
    output logic [15:0] pixel
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] bar;

    always_comb begin
        bar   = 3'(x / 16'(BAR_W));
        pixel = 16'h0000;
        case (sel)
            PAT_BARS:    pixel = BAR_COLOURS[bar];
            PAT_GRAD:    pixel = {x[4:0], x[5:0], x[4:0]};
            PAT_CHECKER: pixel = (x[3] ^ row[3]) ? 16'hFFFF : 16'h0000;
            PAT_COUNTER: pixel = pixcnt;
            default:     pixel = 16'h0000;
        endcase
    end

endmodule

// File: rtl/dvp_pattern_tx.sv
// DVP camera emulator: vsync/href/8-bit RGB565 byte stream, high byte first.
// Optional build macro: DVP_TX_FRAME_TAG_EN puts frame_cnt_o in pixel (0,0).
//
// state     | meaning
// ST_IDLE   | stopped, outputs 0, waiting for enable_i
// ST_VSYNC  | V_SYNC lines with vsync high
// ST_VBACK  | V_BACK blank lines before the first active line
// ST_ACTIVE | V_ACTIVE lines, href high for 2*H_ACTIVE bytes
// ST_VFRONT | V_FRONT blank lines; frame counted and enable_i sampled at end
module dvp_pattern_tx
    import dvp_tx_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 160,
    parameter int V_SYNC   = 3,
    parameter int V_BACK   = 20,
    parameter int V_FRONT  = 10
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        enable_i,
    input  logic [1:0]  pattern_sel_i,
    output logic        cmos_vsync_o,
    output logic        cmos_href_o,
    output logic [7:0]  cmos_data_o,
    output logic        frame_start_o,
    output logic [15:0] frame_cnt_o,
    output logic        busy_o
);

    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int CW       = $clog2(LINE_LEN);
    localparam logic [CW-1:0] COL_LAST = CW'(LINE_LEN - 1);
    localparam logic [CW-1:0] COL_HREF = CW'(2 * H_ACTIVE);

    state_e      state, state_nxt;
    logic [CW-1:0] col, col_nxt;
    logic [15:0] lines_left, lines_nxt;
    logic [15:0] y, y_nxt;
    logic [15:0] pixcnt, pixcnt_nxt;
    logic [1:0]  sel, sel_nxt;
    logic [15:0] fcnt_nxt;
    logic        start_frame;
    logic [15:0] x_nxt;
    logic [15:0] pix_pattern, pix_out;
    logic        href_nxt;
    logic [7:0]  data_nxt;

    always_comb begin
        state_nxt   = state;
        col_nxt     = col;
        lines_nxt   = lines_left;
        y_nxt       = y;
        pixcnt_nxt  = pixcnt;
        sel_nxt     = sel;
        fcnt_nxt    = frame_cnt_o;
        start_frame = 1'b0;

        if (state == ST_IDLE) begin
            start_frame = enable_i;
        end else begin
            col_nxt = (col == COL_LAST) ? '0 : col + CW'(1);
            // A pixel is complete once its low byte (odd column) has gone out.
            if (state == ST_ACTIVE && col < COL_HREF && col[0])
                pixcnt_nxt = pixcnt + 16'd1;
            if (col == COL_LAST) begin
                if (lines_left != 16'd0) begin
                    lines_nxt = lines_left - 16'd1;
                    if (state == ST_ACTIVE)
                        y_nxt = y + 16'd1;
                end else begin
                    case (state)
                        ST_VSYNC: begin
                            state_nxt = ST_VBACK;
                            lines_nxt = 16'(V_BACK - 1);
                        end
                        ST_VBACK: begin
                            state_nxt = ST_ACTIVE;
                            lines_nxt = 16'(V_ACTIVE - 1);
                            y_nxt     = '0;
                        end
                        ST_ACTIVE: begin
                            state_nxt = ST_VFRONT;
                            lines_nxt = 16'(V_FRONT - 1);
                        end
                        ST_VFRONT: begin
                            fcnt_nxt    = frame_cnt_o + 16'd1;
                            state_nxt   = ST_IDLE;
                            start_frame = enable_i;
                        end
                        default: state_nxt = ST_IDLE;
                    endcase
                end
            end
        end

        if (start_frame) begin
            state_nxt  = ST_VSYNC;
            col_nxt    = '0;
            lines_nxt  = 16'(V_SYNC - 1);
            y_nxt      = '0;
            pixcnt_nxt = '0;
            sel_nxt    = pattern_sel_i;
        end
    end

    assign x_nxt = 16'(col_nxt >> 1);

    dvp_pixel_gen #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pixel_gen (
        .sel    (sel_nxt),
        .x      (x_nxt),
        .row    (y_nxt[3:0]),
        .pixcnt (pixcnt_nxt),
        .pixel  (pix_pattern)
    );

    always_comb begin
`ifdef DVP_TX_FRAME_TAG_EN
        pix_out = (x_nxt == 16'd0 && y_nxt == 16'd0) ? fcnt_nxt : pix_pattern;
`else
        pix_out = pix_pattern;
`endif
        href_nxt = (state_nxt == ST_ACTIVE) && (col_nxt < COL_HREF);
        data_nxt = 8'h00;
        if (href_nxt)
            data_nxt = col_nxt[0] ? pix_out[7:0] : pix_out[15:8];
    end

    // Outputs are registered from next-state values so they line up with the state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= ST_IDLE;
            col           <= '0;
            lines_left    <= '0;
            y             <= '0;
            pixcnt        <= '0;
            sel           <= '0;
            frame_cnt_o   <= '0;
            cmos_vsync_o  <= 1'b0;
            cmos_href_o   <= 1'b0;
            cmos_data_o   <= 8'h00;
            frame_start_o <= 1'b0;
            busy_o        <= 1'b0;
        end else begin
            state         <= state_nxt;
            col           <= col_nxt;
            lines_left    <= lines_nxt;
            y             <= y_nxt;
            pixcnt        <= pixcnt_nxt;
            sel           <= sel_nxt;
            frame_cnt_o   <= fcnt_nxt;
            cmos_vsync_o  <= (state_nxt == ST_VSYNC);
            cmos_href_o   <= href_nxt;
            cmos_data_o   <= data_nxt;
            frame_start_o <= start_frame;
            busy_o        <= (state_nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// Scoreboard bench for dvp_pattern_tx: per-frame expectations queued, monitor compares each cycle.
`timescale 1ns/1ps
module tb_dvp_pattern_tx;

    localparam int H_ACTIVE  = 8;
    localparam int V_ACTIVE  = 4;
    localparam int H_BLANK   = 4;
    localparam int V_SYNC    = 1;
    localparam int V_BACK    = 1;
    localparam int V_FRONT   = 1;
    localparam int LINE_LEN  = 2 * H_ACTIVE + H_BLANK;
    localparam int FRAME_LEN = LINE_LEN * (V_SYNC + V_BACK + V_ACTIVE + V_FRONT);
`ifdef DVP_TX_FRAME_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        enable_i = 1'b0;
    logic [1:0]  pattern_sel_i = 2'd0;
    logic        cmos_vsync_o;
    logic        cmos_href_o;
    logic [7:0]  cmos_data_o;
    logic        frame_start_o;
    logic [15:0] frame_cnt_o;
    logic        busy_o;

    dvp_pattern_tx #(
        .H_ACTIVE (H_ACTIVE), .V_ACTIVE (V_ACTIVE), .H_BLANK (H_BLANK),
        .V_SYNC   (V_SYNC),   .V_BACK   (V_BACK),   .V_FRONT (V_FRONT)
    ) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .enable_i      (enable_i),
        .pattern_sel_i (pattern_sel_i),
        .cmos_vsync_o  (cmos_vsync_o),
        .cmos_href_o   (cmos_href_o),
        .cmos_data_o   (cmos_data_o),
        .frame_start_o (frame_start_o),
        .frame_cnt_o   (frame_cnt_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        vsync;
        logic        href;
        logic        fstart;
        logic        busy;
        logic [15:0] fcnt;
    } ctrl_t;

    ctrl_t       ctrl_q[$];
    logic [7:0]  data_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] fcnt_model = 16'd0;
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [15:0] model_pixel(input logic [1:0] sel, input int x, input int y,
                                                input logic [15:0] fcnt);
        logic [15:0] xv;
        logic [15:0] yv;
        xv = 16'(x);
        yv = 16'(y);
        if (TAG_EN && x == 0 && y == 0) return fcnt;
        case (sel)
            2'd0:    return bars[x / (H_ACTIVE / 8)];
            2'd1:    return {xv[4:0], xv[5:0], xv[4:0]};
            2'd2:    return (xv[3] ^ yv[3]) ? 16'hFFFF : 16'h0000;
            default: return 16'(y * H_ACTIVE + x);
        endcase
    endfunction

    task automatic push_idle(input int n, input logic [15:0] fcnt);
        ctrl_t e;
        e = '0;
        e.fcnt = fcnt;
        for (int i = 0; i < n; i++) ctrl_q.push_back(e);
    endtask

    task automatic push_frame(input logic [1:0] sel, input logic [15:0] fcnt);
        ctrl_t       e;
        int          line;
        int          col;
        bit          active;
        logic [15:0] pix;
        for (int p = 0; p < FRAME_LEN; p++) begin
            line     = p / LINE_LEN;
            col      = p % LINE_LEN;
            active   = (line >= V_SYNC + V_BACK) && (line < V_SYNC + V_BACK + V_ACTIVE);
            e.vsync  = (line < V_SYNC);
            e.href   = active && (col < 2 * H_ACTIVE);
            e.fstart = (p == 0);
            e.busy   = 1'b1;
            e.fcnt   = fcnt;
            ctrl_q.push_back(e);
        end
        for (int y = 0; y < V_ACTIVE; y++)
            for (int x = 0; x < H_ACTIVE; x++) begin
                pix = model_pixel(sel, x, y, fcnt);
                data_q.push_back(pix[15:8]);
                data_q.push_back(pix[7:0]);
            end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (ctrl_q.size() > 0 && guard < 4 * FRAME_LEN) begin
            @(posedge clk_i);
            guard++;
        end
        if (ctrl_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d entries left, required 0", ctrl_q.size());
            ctrl_q.delete();
            data_q.delete();
        end
        @(posedge clk_i);
        #1;
    endtask

    // n frames back to back; sel1 applied mid-frame 1, enable dropped in line 2 of the last frame.
    task automatic run_frames(input int n, input logic [1:0] sel0, input logic [1:0] sel1);
        drain();
        pattern_sel_i = sel0;
        enable_i      = 1'b1;
        push_idle(1, fcnt_model);
        for (int i = 0; i < n; i++)
            push_frame((i == 0) ? sel0 : sel1, 16'(fcnt_model + 16'(i)));
        fcnt_model = 16'(fcnt_model + 16'(n));
        push_idle(10, fcnt_model);
        repeat (61) @(posedge clk_i);
        #1;
        pattern_sel_i = sel1;
        repeat (FRAME_LEN * (n - 1) + 25) @(posedge clk_i);
        #1;
        enable_i = 1'b0;
    endtask

    initial begin : monitor
        ctrl_t e;
        forever begin
            @(negedge clk_i);
            if (ctrl_q.size() > 0) begin
                e = ctrl_q.pop_front();
                check("ctrl{vsync,href,fstart,busy}",
                      {28'd0, cmos_vsync_o, cmos_href_o, frame_start_o, busy_o},
                      {28'd0, e.vsync, e.href, e.fstart, e.busy});
                check("frame_cnt", {16'd0, frame_cnt_o}, {16'd0, e.fcnt});
                if (cmos_href_o) begin
                    if (data_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL data_underflow: got byte %0h, no byte expected", cmos_data_o);
                    end else begin
                        check("data", {24'd0, cmos_data_o}, {24'd0, data_q.pop_front()});
                    end
                end else begin
                    check("data_blank", {24'd0, cmos_data_o}, 32'd0);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst_n_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_vsync", {31'd0, cmos_vsync_o}, 32'd0);
        check("reset_href", {31'd0, cmos_href_o}, 32'd0);
        check("reset_data", {24'd0, cmos_data_o}, 32'd0);
        check("reset_fstart", {31'd0, frame_start_o}, 32'd0);
        check("reset_fcnt", {16'd0, frame_cnt_o}, 32'd0);
        check("reset_busy", {31'd0, busy_o}, 32'd0);
        rst_n_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        check("idle_busy", {31'd0, busy_o}, 32'd0);

        run_frames(2, 2'd0, 2'd3);
        run_frames(2, 2'd3, 2'd3);
        run_frames(1, 2'd2, 2'd1);
        run_frames(1, 2'd1, 2'd0);
        for (int i = 0; i < 3; i++)
            run_frames(1 + int'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       2'($urandom_range(0, 3)));

        drain();
        force dut.frame_cnt_o = 16'hFFFF;
        @(posedge clk_i);
        #1;
        release dut.frame_cnt_o;
        fcnt_model = 16'hFFFF;
        check("fcnt_preload", {16'd0, frame_cnt_o}, 32'h0000FFFF);
        run_frames(1, 2'd3, 2'd0);
        drain();
        check("fcnt_wrap", {16'd0, frame_cnt_o}, 32'd0);

        drain();
        pattern_sel_i = 2'd0;
        enable_i      = 1'b1;
        push_idle(1, fcnt_model);
        push_frame(2'd0, fcnt_model);
        repeat (51) @(posedge clk_i);
        #1;
        check("pre_reset_href", {31'd0, cmos_href_o}, 32'd1);
        rst_n_i = 1'b0;
        ctrl_q.delete();
        data_q.delete();
        #1;
        check("midreset_outputs",
              {11'd0, cmos_vsync_o, cmos_href_o, frame_start_o, cmos_data_o, frame_cnt_o == 16'd0 ? 1'b0 : 1'b1, 3'd0, 8'd0},
              32'd0);
        check("midreset_fcnt", {16'd0, frame_cnt_o}, 32'd0);
        check("midreset_busy", {31'd0, busy_o}, 32'd0);
        enable_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_n_i    = 1'b1;
        fcnt_model = 16'd0;
        push_idle(5, fcnt_model);
        drain();
        run_frames(1, 2'd0, 2'd0);
        drain();
        check("data_queue_empty", data_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
